// File: rtl/mips_dbg_pkg.sv
// Shared command/ack codes and loader FSM states for the MIPS debug loader.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mips_dbg_pkg;

    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_RUN  = 8'h02;
    localparam logic [7:0] CMD_STEP = 8'h03;
    localparam logic [7:0] CMD_HALT = 8'h04;

    localparam logic [7:0] ACK_LOAD = 8'hA1;
    localparam logic [7:0] ACK_RUN  = 8'hA2;
    localparam logic [7:0] ACK_STEP = 8'hA3;
    localparam logic [7:0] ACK_HALT = 8'hA4;
    localparam logic [7:0] ACK_ERR  = 8'hEE;

    typedef enum logic [2:0] {
        IDLE,
        L_CNT,
        L_BYTE,
        WR,
        L_CHK,
        STEP,
        ACK
    } state_t;

endpackage

// File: rtl/byte_to_word.sv
// Packs a byte stream into 32-bit words, first byte lands in bits [31:24].
// Latency: word_dat updates on the edge accepting each byte; word_done is high in the 4th byte's accept cycle.
// Backpressure: none; every byte_vld is consumed.
module byte_to_word (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_vld,
    input  logic [7:0]  byte_dat,
    output logic        word_done,
    output logic [31:0] word_dat
);

    logic [1:0] byte_cnt;

    assign word_done = byte_vld && (byte_cnt == 2'd3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt <= '0;
            word_dat <= '0;
        end else if (clr) begin
            byte_cnt <= '0;
            word_dat <= '0;
        end else if (byte_vld) begin
            byte_cnt <= byte_cnt + 2'd1;
            word_dat <= {word_dat[23:0], byte_dat};
        end
    end

endmodule

// File: rtl/debug_loader.sv
// UART-command loader: writes instruction memory, controls core stall, acks every command.
// Latency: write strobe 1 cycle after 4th byte of a word; ack follows command/last byte by 1-2 cycles.
// Backpressure: none on rx (bytes in WR/ACK dropped); ack held until i_ack_ready. DEBUG_LOADER_CHECKSUM_EN adds an XOR checksum byte.
module debug_loader
    import mips_dbg_pkg::*;
#(
    parameter int IMEM_WORDS = 256,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_data,
    output logic              o_stall,
    output logic              o_core_rst,
    output logic              o_ack_valid,
    output logic [7:0]        o_ack_data,
    input  logic              i_ack_ready,
    output logic              o_busy
);

    localparam int IDX_W = $clog2(IMEM_WORDS);

    state_t           state;
    logic [IDX_W-1:0] word_idx;
    logic [7:0]       words_left;
    logic             b2w_clr;
    logic             b2w_vld;
    logic             word_done;
    logic [31:0]      word_dat;
`ifdef DEBUG_LOADER_CHECKSUM_EN
    logic [7:0]       chk_acc;
`endif

    assign b2w_clr     = i_rx_valid && (state == IDLE) && (i_rx_data == CMD_LOAD);
    assign b2w_vld     = i_rx_valid && (state == L_BYTE);
    assign o_imem_data = word_dat;
    assign o_busy      = (state != IDLE);

    byte_to_word u_byte_to_word (
        .clk       (clk),
        .rst       (rst),
        .clr       (b2w_clr),
        .byte_vld  (b2w_vld),
        .byte_dat  (i_rx_data),
        .word_done (word_done),
        .word_dat  (word_dat)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            word_idx    <= '0;
            words_left  <= '0;
            o_imem_we   <= 1'b0;
            o_imem_addr <= '0;
            o_stall     <= 1'b1;
            o_core_rst  <= 1'b0;
            o_ack_valid <= 1'b0;
            o_ack_data  <= '0;
`ifdef DEBUG_LOADER_CHECKSUM_EN
            chk_acc     <= '0;
`endif
        end else begin
            o_imem_we  <= 1'b0;
            o_core_rst <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_rx_valid) begin
                        case (i_rx_data)
                            CMD_LOAD: begin
                                o_stall  <= 1'b1;
                                word_idx <= '0;
                                state    <= L_CNT;
                            end
                            CMD_RUN: begin
                                o_stall     <= 1'b0;
                                o_ack_valid <= 1'b1;
                                o_ack_data  <= ACK_RUN;
                                state       <= ACK;
                            end
                            CMD_STEP: begin
                                o_stall <= 1'b0;
                                state   <= STEP;
                            end
                            CMD_HALT: begin
                                o_stall     <= 1'b1;
                                o_ack_valid <= 1'b1;
                                o_ack_data  <= ACK_HALT;
                                state       <= ACK;
                            end
                            default: begin
                                o_ack_valid <= 1'b1;
                                o_ack_data  <= ACK_ERR;
                                state       <= ACK;
                            end
                        endcase
                    end
                end
                L_CNT: begin
                    if (i_rx_valid) begin
                        if (i_rx_data == 8'd0) begin
                            o_ack_valid <= 1'b1;
                            o_ack_data  <= ACK_LOAD;
                            state       <= ACK;
                        end else if (32'(i_rx_data) > IMEM_WORDS) begin
                            o_ack_valid <= 1'b1;
                            o_ack_data  <= ACK_ERR;
                            state       <= ACK;
                        end else begin
                            words_left <= i_rx_data;
                            state      <= L_BYTE;
`ifdef DEBUG_LOADER_CHECKSUM_EN
                            chk_acc    <= '0;
`endif
                        end
                    end
                end
                L_BYTE: begin
`ifdef DEBUG_LOADER_CHECKSUM_EN
                    if (i_rx_valid)
                        chk_acc <= chk_acc ^ i_rx_data;
`endif
                    if (word_done) begin
                        o_imem_we   <= 1'b1;
                        o_imem_addr <= ADDR_W'({word_idx, 2'b00});
                        state       <= WR;
                    end
                end
                WR: begin
                    word_idx   <= word_idx + 1'b1;
                    words_left <= words_left - 8'd1;
                    if (words_left == 8'd1) begin
`ifdef DEBUG_LOADER_CHECKSUM_EN
                        state       <= L_CHK;
`else
                        o_core_rst  <= 1'b1;
                        o_ack_valid <= 1'b1;
                        o_ack_data  <= ACK_LOAD;
                        state       <= ACK;
`endif
                    end else begin
                        state <= L_BYTE;
                    end
                end
`ifdef DEBUG_LOADER_CHECKSUM_EN
                L_CHK: begin
                    if (i_rx_valid) begin
                        // a bad checksum leaves the core held in reset-free stall
                        o_core_rst  <= (i_rx_data == chk_acc);
                        o_ack_valid <= 1'b1;
                        o_ack_data  <= (i_rx_data == chk_acc) ? ACK_LOAD : ACK_ERR;
                        state       <= ACK;
                    end
                end
`endif
                STEP: begin
                    o_stall     <= 1'b1;
                    o_ack_valid <= 1'b1;
                    o_ack_data  <= ACK_STEP;
                    state       <= ACK;
                end
                ACK: begin
                    if (i_ack_ready) begin
                        o_ack_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
